// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Optional macro IMEM_PARITY_EN adds a per-word even-parity bit and a parity flag per stage.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam int          MIN_READ_LATENCY     = 1;
    localparam int          MAX_READ_LATENCY     = 4;
    localparam int          DEFAULT_ADDRESS_BITS = 16;

    // Pipeline stage record; the top re-declares it at its own PC width.
    typedef struct packed {
        logic                            valid;
        logic [DEFAULT_ADDRESS_BITS-1:0] pc;
        logic [31:0]                     data;
        logic                            fault;
`ifdef IMEM_PARITY_EN
        logic                            perr;
`endif
    } stage_t;

    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request, load port and response.
// With IMEM_PARITY_EN defined the bus also carries parity_error.
interface imem_responder_if #(
    parameter int ADDRESS_BITS = 16
) ();

    logic [ADDRESS_BITS-1:0] PC;
    logic                    flush;
    logic                    load_enable;
    logic [ADDRESS_BITS-1:0] load_address;
    logic [31:0]             load_data;
    logic [31:0]             instruction;
    logic [ADDRESS_BITS-1:0] instr_PC;
    logic                    instr_valid;
    logic                    fetch_fault;
`ifdef IMEM_PARITY_EN
    logic                    parity_error;
`endif

    modport master (
        output PC, flush, load_enable, load_address, load_data,
`ifdef IMEM_PARITY_EN
        input  parity_error,
`endif
        input  instruction, instr_PC, instr_valid, fetch_fault
    );

    modport slave (
        input  PC, flush, load_enable, load_address, load_data,
`ifdef IMEM_PARITY_EN
        output parity_error,
`endif
        output instruction, instr_PC, instr_valid, fetch_fault
    );

endinterface

// File: rtl/imem_responder_delay_line.sv
// Chain of response stage records: async reset, synchronous flush that clears every valid bit.
// An invalid stage keeps its payload so the last response stays visible on the outputs.
module imem_delay_line #(
    parameter int  STAGES    = 1,
    parameter type stage_t   = imem_pkg::stage_t,
    parameter stage_t RESET_VAL = '0
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   flush_i,
    input  stage_t in_i,
    output stage_t out_o
);

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        stage_t prev_s;
        stage_t stage_q;

        if (g == 0) begin : g_head
            assign prev_s = in_i;
        end else begin : g_link
            assign prev_s = g_stage[g-1].stage_q;
        end

        // Advance one record per edge; flush or a bubble only drops the valid flag.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                stage_q <= RESET_VAL;
            end else if (flush_i || !prev_s.valid) begin
                stage_q.valid <= 1'b0;
`ifdef IMEM_PARITY_EN
                stage_q.perr  <= 1'b0;
`endif
            end else begin
                stage_q <= prev_s;
            end
        end
    end

    assign out_o = g_stage[STAGES-1].stage_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency word read for fetch, redirect flush, program load port.
// Optional macro IMEM_PARITY_EN: stored even parity, rechecked on read, reported via parity_error.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDRESS_BITS = 16,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input logic           clock,
    input logic           reset,
    imem_responder_if.slave bus
);

    if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("imem_responder: READ_LATENCY %0d outside 1..4", READ_LATENCY);
    end
    if (DEPTH_WORDS < 1 || DEPTH_WORDS > (1 << (ADDRESS_BITS - 2))) begin : g_bad_depth
        $error("imem_responder: DEPTH_WORDS %0d outside legal range", DEPTH_WORDS);
    end

    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef IMEM_PARITY_EN
    localparam int WORD_W = 33;
`else
    localparam int WORD_W = 32;
`endif

    typedef struct packed {
        logic                    valid;
        logic [ADDRESS_BITS-1:0] pc;
        logic [31:0]             data;
        logic                    fault;
`ifdef IMEM_PARITY_EN
        logic                    perr;
`endif
    } rsp_stage_t;

`ifdef IMEM_PARITY_EN
    localparam rsp_stage_t RST_STAGE = '{valid: 1'b0, pc: '0, data: NOP_INSTR, fault: 1'b0, perr: 1'b0};
`else
    localparam rsp_stage_t RST_STAGE = '{valid: 1'b0, pc: '0, data: NOP_INSTR, fault: 1'b0};
`endif

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]  ld_idx_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic              ld_in_range_s;
    logic              rd_in_range_s;
    logic              rd_misaligned_s;
    logic [WORD_W-1:0] rd_word_s;
    logic              unused_addr_s;
    rsp_stage_t        cap_s;
    rsp_stage_t        out_s;

    assign ld_in_range_s   = 32'(bus.load_address[ADDRESS_BITS-1:2]) < 32'(DEPTH_WORDS);
    assign rd_in_range_s   = 32'(bus.PC[ADDRESS_BITS-1:2]) < 32'(DEPTH_WORDS);
    assign rd_misaligned_s = (bus.PC[1:0] != 2'b00);
    assign ld_idx_s        = IDX_W'(bus.load_address[ADDRESS_BITS-1:2]);
    // Out-of-range reads are steered to word 0 so the array is never indexed past its end.
    assign rd_idx_s        = rd_in_range_s ? IDX_W'(bus.PC[ADDRESS_BITS-1:2]) : '0;
    assign rd_word_s       = mem_q[rd_idx_s];
    assign unused_addr_s   = &{1'b0, bus.load_address[1:0]};

    // Program load port; storage is intentionally not reset and out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        if (bus.load_enable && ld_in_range_s) begin
`ifdef IMEM_PARITY_EN
            mem_q[ld_idx_s] <= {even_parity(bus.load_data), bus.load_data};
`else
            mem_q[ld_idx_s] <= bus.load_data;
`endif
        end
    end

    // Form the record captured at this edge; faulted requests carry NOP.
    always_comb begin
        cap_s       = RST_STAGE;
        cap_s.valid = 1'b1;
        cap_s.pc    = bus.PC;
`ifdef IMEM_PARITY_EN
        cap_s.perr  = rd_in_range_s && !rd_misaligned_s && (^rd_word_s);
        cap_s.fault = rd_misaligned_s || !rd_in_range_s || cap_s.perr;
`else
        cap_s.fault = rd_misaligned_s || !rd_in_range_s;
`endif
        if (cap_s.fault) begin
            cap_s.data = NOP_INSTR;
        end else begin
            cap_s.data = rd_word_s[31:0];
        end
    end

    imem_delay_line #(
        .STAGES    (READ_LATENCY),
        .stage_t   (rsp_stage_t),
        .RESET_VAL (RST_STAGE)
    ) u_delay_line (
        .clock   (clock),
        .reset   (reset),
        .flush_i (bus.flush),
        .in_i    (cap_s),
        .out_o   (out_s)
    );

    assign bus.instruction = out_s.data;
    assign bus.instr_PC    = out_s.pc;
    assign bus.instr_valid = out_s.valid;
    assign bus.fetch_fault = out_s.fault;
`ifdef IMEM_PARITY_EN
    assign bus.parity_error = out_s.perr;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: three responders (latency 1, 2, 3) share one stimulus stream.
module tb_imem_responder;
    import imem_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc_r = 16'h0000;
    logic        flush_r = 1'b0;
    logic        ld_en_r = 1'b0;
    logic [15:0] ld_addr_r = 16'h0000;
    logic [31:0] ld_data_r = 32'h0000_0000;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m [11];

    imem_responder_if #(.ADDRESS_BITS(16)) bus1 ();
    imem_responder_if #(.ADDRESS_BITS(16)) bus2 ();
    imem_responder_if #(.ADDRESS_BITS(16)) bus3 ();

    assign bus1.PC = pc_r;  assign bus1.flush = flush_r;  assign bus1.load_enable = ld_en_r;
    assign bus1.load_address = ld_addr_r;  assign bus1.load_data = ld_data_r;
    assign bus2.PC = pc_r;  assign bus2.flush = flush_r;  assign bus2.load_enable = ld_en_r;
    assign bus2.load_address = ld_addr_r;  assign bus2.load_data = ld_data_r;
    assign bus3.PC = pc_r;  assign bus3.flush = flush_r;  assign bus3.load_enable = ld_en_r;
    assign bus3.load_address = ld_addr_r;  assign bus3.load_data = ld_data_r;

    imem_responder #(.ADDRESS_BITS(16), .DEPTH_WORDS(1024), .READ_LATENCY(1))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));
    imem_responder #(.ADDRESS_BITS(16), .DEPTH_WORDS(1024), .READ_LATENCY(2))
        dut2 (.clock(clock), .reset(reset), .bus(bus2));
    imem_responder #(.ADDRESS_BITS(16), .DEPTH_WORDS(1024), .READ_LATENCY(3))
        dut3 (.clock(clock), .reset(reset), .bus(bus3));

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [15:0] addr, input logic [31:0] data);
        ld_en_r   = 1'b1;
        ld_addr_r = addr;
        ld_data_r = data;
        step();
        ld_en_r   = 1'b0;
    endtask

    initial begin
        m[0] = 32'h0050_0093;
        m[1] = 32'h0010_8113;
        for (int i = 2; i < 11; i++) m[i] = 32'h0A00_0000 + 32'(i);

        for (int i = 0; i < 11; i++) load_word(16'(4 * i), m[i]);
        load_word(16'h0F04, 32'hA5A5_0F04);

        check_eq("rst_valid1", 64'(bus1.instr_valid), 64'h0);
        check_eq("rst_instr1", 64'(bus1.instruction), 64'h13);
        check_eq("rst_pc1",    64'(bus1.instr_PC),    64'h0);
        check_eq("rst_fault1", 64'(bus1.fetch_fault), 64'h0);
        check_eq("rst_valid3", 64'(bus3.instr_valid), 64'h0);
        check_eq("rst_instr3", 64'(bus3.instruction), 64'h13);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            pc_r = 16'(4 * i);
            step();
            check_eq("sweep_v1",  64'(bus1.instr_valid), 64'h1);
            check_eq("sweep_i1",  64'(bus1.instruction), 64'(m[i]));
            check_eq("sweep_pc1", 64'(bus1.instr_PC),    64'(4 * i));
            if (i >= 1) check_eq("sweep_i2", 64'(bus2.instruction), 64'(m[i-1]));
            else        check_eq("sweep_v2", 64'(bus2.instr_valid), 64'h0);
            if (i >= 2) begin
                check_eq("sweep_v3",  64'(bus3.instr_valid), 64'h1);
                check_eq("sweep_i3",  64'(bus3.instruction), 64'(m[i-2]));
                check_eq("sweep_pc3", 64'(bus3.instr_PC),    64'(4 * (i - 2)));
            end else begin
                check_eq("sweep_v3_empty", 64'(bus3.instr_valid), 64'h0);
            end
        end

        // Redirect: the branch-shadow PC must never produce a live response.
        pc_r = 16'h0010; step();
        pc_r = 16'h0014; step();
        check_eq("pre_flush_i1", 64'(bus1.instruction), 64'(m[5]));
        pc_r = 16'h0018; flush_r = 1'b1; step();
        flush_r = 1'b0;
        check_eq("flush_v1",   64'(bus1.instr_valid), 64'h0);
        check_eq("flush_hold", 64'(bus1.instr_PC),    64'h14);
        check_eq("flush_v2",   64'(bus2.instr_valid), 64'h0);
        check_eq("flush_v3",   64'(bus3.instr_valid), 64'h0);
        pc_r = 16'hFF00; step();
        check_eq("oor_v1",     64'(bus1.instr_valid), 64'h1);
        check_eq("oor_pc1",    64'(bus1.instr_PC),    64'hFF00);
        check_eq("oor_i1",     64'(bus1.instruction), 64'h13);
        check_eq("oor_f1",     64'(bus1.fetch_fault), 64'h1);
        check_eq("shadow_v2",  64'(bus2.instr_valid), 64'h0);
        check_eq("shadow_v3",  64'(bus3.instr_valid), 64'h0);

        pc_r = 16'h0006; step();
        check_eq("mis_v1",  64'(bus1.instr_valid), 64'h1);
        check_eq("mis_f1",  64'(bus1.fetch_fault), 64'h1);
        check_eq("mis_i1",  64'(bus1.instruction), 64'h13);
        check_eq("mis_pc1", 64'(bus1.instr_PC),    64'h6);
        check_eq("oor_pc2", 64'(bus2.instr_PC),    64'hFF00);
        check_eq("oor_f2",  64'(bus2.fetch_fault), 64'h1);
        check_eq("lag_v3",  64'(bus3.instr_valid), 64'h0);

        // Same-edge load and read of one word returns the old contents.
        pc_r = 16'h0008;
        load_word(16'h0008, 32'hDEAD_BEEF);
        check_eq("rfirst_i1", 64'(bus1.instruction), 64'(m[2]));
        check_eq("oor_pc3",   64'(bus3.instr_PC),    64'hFF00);
        check_eq("mis_f2",    64'(bus2.fetch_fault), 64'h1);
        step();
        check_eq("newdata_i1", 64'(bus1.instruction), 64'hDEAD_BEEF);
        check_eq("rfirst_i2",  64'(bus2.instruction), 64'(m[2]));
        check_eq("mis_pc3",    64'(bus3.instr_PC),    64'h6);

        // Out-of-range load must not alias onto a low word.
        pc_r = 16'h0F04;
        load_word(16'hFF04, 32'h1234_5678);
        step();
        check_eq("nowrap_i1", 64'(bus1.instruction), 64'hA5A5_0F04);
        check_eq("nowrap_f1", 64'(bus1.fetch_fault), 64'h0);

        // Byte offset of the load address is ignored.
        pc_r = 16'h000C;
        load_word(16'h000E, 32'h0000_0077);
        check_eq("mload_old", 64'(bus1.instruction), 64'(m[3]));
        step();
        check_eq("mload_new", 64'(bus1.instruction), 64'h77);

        // Asynchronous reset with requests in flight.
        pc_r = 16'h0000; step();
        pc_r = 16'h0004; step();
        check_eq("inflight_v2", 64'(bus2.instr_valid), 64'h1);
        reset = 1'b1;
        #1;
        check_eq("arst_v1", 64'(bus1.instr_valid), 64'h0);
        check_eq("arst_i1", 64'(bus1.instruction), 64'h13);
        check_eq("arst_v2", 64'(bus2.instr_valid), 64'h0);
        check_eq("arst_v3", 64'(bus3.instr_valid), 64'h0);
        step();
        reset = 1'b0;
        pc_r = 16'h000C; step();
        check_eq("post_v1",  64'(bus1.instr_valid), 64'h1);
        check_eq("post_i1",  64'(bus1.instruction), 64'h77);
        check_eq("stale_v2", 64'(bus2.instr_valid), 64'h0);
        check_eq("stale_v3", 64'(bus3.instr_valid), 64'h0);
        pc_r = 16'h0010; step();
        check_eq("post_pc2", 64'(bus2.instr_PC),    64'hC);
        check_eq("post_v2",  64'(bus2.instr_valid), 64'h1);
        check_eq("stale2_v3", 64'(bus3.instr_valid), 64'h0);
        pc_r = 16'h0014; step();
        check_eq("post_i3", 64'(bus3.instruction), 64'h77);

`ifdef IMEM_PARITY_EN
        dut1.mem_q[4][0] = ~dut1.mem_q[4][0];
        pc_r = 16'h0010; step();
        check_eq("par_err", 64'(bus1.parity_error), 64'h1);
        check_eq("par_flt", 64'(bus1.fetch_fault),  64'h1);
        check_eq("par_nop", 64'(bus1.instruction),  64'h13);
        pc_r = 16'h0014; step();
        check_eq("par_clr", 64'(bus1.parity_error), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
